// File: rtl/instr_exec_unit.sv
// instr_exec_unit: single-issue execution unit with a valid/ready handshake on both sides.
// ZERO/PASSA/PASSB/ADD/SUB/MULT finish one cycle after accept. DIV/MOD run a restoring
// divider on the operand magnitudes, one quotient bit per cycle. All results are
// sign-extended to 2*OP_WIDTH bits.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake (opc, op_a, op_b captured on accept)
//   opc                 ZERO=0 PASSA=1 PASSB=2 ADD=3 SUB=4 MULT=5 DIV=6 MOD=7
//   op_a, op_b          signed operands
//   out_valid/out_ready result handshake
//   rez                 signed result, 2*OP_WIDTH bits
//   div_by_zero         DIV/MOD with op_b==0; qualified by out_valid
module instr_exec_unit #(
  parameter int unsigned OP_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              opc,
  input  logic [OP_WIDTH-1:0]     op_a,
  input  logic [OP_WIDTH-1:0]     op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*OP_WIDTH-1:0]   rez,
  output logic                    div_by_zero
);

  localparam int unsigned W    = OP_WIDTH;
  localparam int unsigned RW   = 2 * OP_WIDTH;
  localparam int unsigned CntW = $clog2(OP_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rez_q;
  logic            dbz_q;
  logic [W-1:0]    rem_q, quo_q, dvsr_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_quo_q, neg_rem_q, is_mod_q;

  logic            accept, is_div_op, b_zero, last_iter;
  logic [RW-1:0]   a_ext, b_ext, simple_res;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      shifted, diff;
  logic            fits;
  logic [W-1:0]    rem_nxt, quo_nxt;
  logic [RW-1:0]   q_mag, r_mag, div_res, mod_res;

  assign accept    = in_valid && in_ready;
  assign is_div_op = (opc == 3'd6) || (opc == 3'd7);
  assign b_zero    = (op_b == '0);
  assign last_iter = (state_q == StDivide) && (cnt_q == CntW'(W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = (is_div_op && !b_zero) ? StDivide : StDone;
      StDivide: if (last_iter) state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs; in_ready is masked by reset so nothing can be accepted while it is held.
  always_comb begin
    in_ready    = (state_q == StIdle) && !reset;
    out_valid   = (state_q == StDone);
    rez         = rez_q;
    div_by_zero = dbz_q;
  end

  // Single-cycle operations at full precision on sign-extended operands
  always_comb begin
    a_ext = {{W{op_a[W-1]}}, op_a};
    b_ext = {{W{op_b[W-1]}}, op_b};
    unique case (opc)
      3'd0:    simple_res = '0;
      3'd1:    simple_res = a_ext;
      3'd2:    simple_res = b_ext;
      3'd3:    simple_res = a_ext + b_ext;
      3'd4:    simple_res = a_ext - b_ext;
      3'd5:    simple_res = a_ext * b_ext;
      default: simple_res = '0;
    endcase
  end

  // Magnitudes; the most-negative value maps to 2^(W-1), which fits unsigned in W bits.
  assign a_mag = op_a[W-1] ? -op_a : op_a;
  assign b_mag = op_b[W-1] ? -op_b : op_b;

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvsr_q};
    fits    = !diff[W];
    rem_nxt = fits ? diff[W-1:0] : shifted[W-1:0];
    quo_nxt = {quo_q[W-2:0], fits};
    q_mag   = {{W{1'b0}}, quo_nxt};
    r_mag   = {{W{1'b0}}, rem_nxt};
    div_res = neg_quo_q ? -q_mag : q_mag;
    mod_res = neg_rem_q ? -r_mag : r_mag;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rez_q     <= '0;
      dbz_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_mod_q  <= 1'b0;
    end else if (accept) begin
      rez_q     <= is_div_op ? '0 : simple_res;
      dbz_q     <= is_div_op && b_zero;
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvsr_q    <= b_mag;
      cnt_q     <= '0;
      neg_quo_q <= op_a[W-1] ^ op_b[W-1];
      neg_rem_q <= op_a[W-1];
      is_mod_q  <= opc[0];
    end else if (state_q == StDivide) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CntW'(1);
      // Sign fix-up folds into the final iteration so DONE follows immediately.
      if (last_iter) rez_q <= is_mod_q ? mod_res : div_res;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: table of directed vectors, model-checked random
// vectors, plus hand-written hold and reset-abort sequences. Expected results go into a
// scoreboard queue at issue time and are popped when out_valid appears.
module tb_instr_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [2:0]    opc;
  logic [W-1:0]  op_a, op_b;
  logic [2*W-1:0] rez;

  always #5 clk = ~clk;

  instr_exec_unit #(.OP_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opc         (opc),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rez         (rez),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [2:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] rez;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] rez;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] r, input logic d, input int l);
    vec_t v;
    v.opc = o; v.a = a; v.b = b; v.rez = r; v.dbz = d; v.lat = l;
    return v;
  endfunction

  // Reference model using 64-bit signed arithmetic (truncating division, dividend-signed mod).
  function automatic vec_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, r;
    vec_t   v;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    v.opc = o; v.a = a; v.b = b; v.dbz = 1'b0; v.lat = 1;
    case (o)
      3'd0: r = 0;
      3'd1: r = sa;
      3'd2: r = sbv;
      3'd3: r = sa + sbv;
      3'd4: r = sa - sbv;
      3'd5: r = sa * sbv;
      default: begin
        if (sbv == 0) begin
          r = 0;
          v.dbz = 1'b1;
        end else begin
          r = (o == 3'd6) ? sa / sbv : sa % sbv;
          v.lat = W + 1;
        end
      end
    endcase
    v.rez = r;
    return v;
  endfunction

  // Starts and ends just after a negedge. hold = cycles of out_ready=0 with junk in_valid.
  task automatic run_vec(input vec_t v, input int hold);
    int   guard;
    int   lat;
    exp_t e;
    exp_t got;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    opc = v.opc; op_a = v.a; op_b = v.b; in_valid = 1'b1;
    e.rez = v.rez; e.dbz = v.dbz; e.lat = v.lat;
    scb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (scb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got result %h expected none", rez);
      got = e;
    end else begin
      got = scb.pop_front();
      chk("rez", rez, got.rez);
      chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, got.dbz});
      chk("latency", 64'(lat), 64'(got.lat));
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      opc = 3'd3;
      op_a = $urandom;
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_rez", rez, got.rez);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  vec_t tbl[16];

  initial begin
    int   seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = mk(3'd3, -32'sd7, 32'd5, -64'sd2, 1'b0, 1);
    tbl[1]  = mk(3'd5, 32'h7FFFFFFF, 32'd2, 64'h00000000FFFFFFFE, 1'b0, 1);
    tbl[2]  = mk(3'd6, -32'sd17, 32'd5, -64'sd3, 1'b0, 33);
    tbl[3]  = mk(3'd7, -32'sd17, 32'd5, -64'sd2, 1'b0, 33);
    tbl[4]  = mk(3'd7, 32'd9, 32'd0, 64'd0, 1'b1, 1);
    tbl[5]  = mk(3'd6, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0, 33);
    tbl[6]  = mk(3'd0, 32'd5, 32'd6, 64'd0, 1'b0, 1);
    tbl[7]  = mk(3'd1, 32'hFFFFFFFF, 32'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1);
    tbl[8]  = mk(3'd2, 32'd1, 32'd12, 64'd12, 1'b0, 1);
    tbl[9]  = mk(3'd4, 32'h80000000, 32'h7FFFFFFF, 64'hFFFFFFFF00000001, 1'b0, 1);
    tbl[10] = mk(3'd5, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 1);
    tbl[11] = mk(3'd6, 32'd7, -32'sd2, -64'sd3, 1'b0, 33);
    tbl[12] = mk(3'd7, 32'd7, -32'sd2, 64'd1, 1'b0, 33);
    tbl[13] = mk(3'd6, 32'd0, 32'd0, 64'd0, 1'b1, 1);
    tbl[14] = mk(3'd6, 32'd3, 32'd7, 64'd0, 1'b0, 33);
    tbl[15] = mk(3'd7, 32'd3, 32'd7, 64'd3, 1'b0, 33);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opc = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_rez", rez, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], 0);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      if (i % 5 == 0)      rb = 32'd0;
      else if (i % 3 == 1) rb = $urandom_range(1, 9);
      else                 rb = $urandom;
      run_vec(model(ro, ra, rb), i % 3);
    end

    // PASSB held for five cycles with junk in_valid, then released.
    run_vec(mk(3'd2, 32'h55, 32'd12, 64'd12, 1'b0, 1), 5);

    // Reset in the middle of a division aborts it; in_valid/out_ready during reset lose.
    opc = 3'd6; op_a = -32'sd1000; op_b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_rez", rez, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("abort_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_release_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_stale_result", 64'(seen), 64'd0);
    run_vec(model(3'd4, 32'd100, 32'd58), 0);
    run_vec(model(3'd7, -32'sd1000, 32'd7), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
